// File: rtl/pipeline.sv
// Shared core pipeline definitions used by the memory arbiter and its
// requester interfaces.
//   ADDR_W / DATA_W / SEL_W : widths of the core-to-cache (c2c) buses
//   mem_grant_e             : which requester currently owns the memory port
//   REQ_* / NUM_REQ         : bit positions of each requester in request vectors
//   grant_onehot()          : grant enum -> request-vector mask of the owner
package pipeline;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam int NUM_REQ    = 3;
  localparam int REQ_INSTR  = 0;
  localparam int REQ_DATA_R = 1;
  localparam int REQ_DATA_W = 2;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_INSTR  = 2'd1,
    GNT_DATA_R = 2'd2,
    GNT_DATA_W = 2'd3
  } mem_grant_e;

  // Maps a grant onto the request-vector bit of the requester that holds it,
  // so the top can test "is my owner still asking" and exclude the owner
  // from the re-pick on a completing transfer.
  function automatic logic [NUM_REQ-1:0] grant_onehot(input mem_grant_e g);
    logic [NUM_REQ-1:0] m;
    m = '0;
    case (g)
      GNT_INSTR:  m[REQ_INSTR]  = 1'b1;
      GNT_DATA_R: m[REQ_DATA_R] = 1'b1;
      GNT_DATA_W: m[REQ_DATA_W] = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/c2c_r.sv
// Core-to-cache read bus.
//   master : drives re, addr, sel; receives data, ack
//   slave  : receives re, addr, sel; drives data, ack
// re is a level held by the master until it sees ack.
interface c2c_r;
  import pipeline::*;

  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] data;
  logic              ack;

  modport master (output re, addr, sel, input data, ack);
  modport slave  (input re, addr, sel, output data, ack);
endinterface

// File: rtl/c2c_w.sv
// Core-to-cache write bus.
//   master : drives we, addr, data, sel; receives ack
//   slave  : receives we, addr, data, sel; drives ack
// we is a level held by the master until it sees ack.
interface c2c_w;
  import pipeline::*;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [SEL_W-1:0]  sel;
  logic              ack;

  modport master (output we, addr, data, sel, input ack);
  modport slave  (input we, addr, data, sel, output ack);
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the memory arbiter.
//   req        : live request levels (indexed by REQ_*)
//   excl       : requesters not eligible this pick (the one just completing)
//   streak_sat : data has won enough times in a row; fetch must go next
//   pick       : grant to load into the grant register
// Order is store > load > fetch, except that a saturated data streak hands
// the port to a waiting fetch.
module mem_arb_pick
  import pipeline::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] excl,
  input  logic               streak_sat,
  output mem_grant_e         pick
);

  logic [NUM_REQ-1:0] avail;

  assign avail = req & ~excl;

  // Fixed-priority selection with the anti-starvation override on top.
  always_comb begin
    pick = GNT_NONE;
    if (streak_sat && avail[REQ_INSTR]) begin
      pick = GNT_INSTR;
    end else if (avail[REQ_DATA_W]) begin
      pick = GNT_DATA_W;
    end else if (avail[REQ_DATA_R]) begin
      pick = GNT_DATA_R;
    end else if (avail[REQ_INSTR]) begin
      pick = GNT_INSTR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port (read + write) between instruction fetch and the LSU.
//   clk, rst_n   : core clock, synchronous active-low reset
//   instr_bus_r  : fetch read requester
//   data_bus_r   : LSU read requester
//   data_bus_w   : LSU write requester
//   mem_bus_r    : shared memory read port
//   mem_bus_w    : shared memory write port
// A registered grant picks one owner; the owner's strobe, address, select
// and write data are forwarded combinationally, and the memory ack is routed
// back only to the owner. The grant is released on ack (with an immediate
// re-pick among the others) or when the owner withdraws its request.
// MAX_DATA_STREAK must be at least 1.
module mem_arbiter
  import pipeline::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input logic  clk,
  input logic  rst_n,
  c2c_r.slave  instr_bus_r,
  c2c_r.slave  data_bus_r,
  c2c_w.slave  data_bus_w,
  c2c_r.master mem_bus_r,
  c2c_w.master mem_bus_w
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  mem_grant_e          grant_q;
  mem_grant_e          grant_d;
  mem_grant_e          pick;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [STREAK_W-1:0] streak_q;
  logic                streak_sat;
  logic                granted_ack;
  logic                data_issue;

  assign req[REQ_INSTR]  = instr_bus_r.re;
  assign req[REQ_DATA_R] = data_bus_r.re;
  assign req[REQ_DATA_W] = data_bus_w.we;

  assign grant_oh   = grant_onehot(grant_q);
  assign streak_sat = (streak_q == STREAK_MAX);

  // Excluding the current owner keeps a requester whose level is still high
  // on its own ack edge from being served twice for one request.
  mem_arb_pick u_pick (
    .req        (req),
    .excl       (grant_oh),
    .streak_sat (streak_sat),
    .pick       (pick)
  );

  // Only the ack belonging to the owner's direction completes the transfer;
  // acks on the other port or with no owner are ignored.
  always_comb begin
    case (grant_q)
      GNT_INSTR, GNT_DATA_R: granted_ack = mem_bus_r.ack;
      GNT_DATA_W:            granted_ack = mem_bus_w.ack;
      default:               granted_ack = 1'b0;
    endcase
  end

  // Next grant: pick when idle or on completion, drop to idle if the owner
  // withdraws before its ack, otherwise hold.
  always_comb begin
    grant_d = grant_q;
    if (grant_q == GNT_NONE || granted_ack) begin
      grant_d = pick;
    end else if ((req & grant_oh) == '0) begin
      grant_d = GNT_NONE;
    end
  end

  // A data grant is "issued" only on the edge it is newly loaded; holding a
  // data grant across wait cycles does not extend the streak.
  assign data_issue = ((grant_d == GNT_DATA_R) || (grant_d == GNT_DATA_W)) &&
                      (grant_d != grant_q);

  // Grant register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q <= GNT_NONE;
    end else begin
      grant_q <= grant_d;
    end
  end

  // Consecutive data grants while fetch waits; saturates so the picker keeps
  // forcing fetch until fetch is actually granted or stops asking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (!instr_bus_r.re || grant_d == GNT_INSTR) begin
      streak_q <= '0;
    end else if (data_issue && !streak_sat) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  // Read data is shared; only the ack tells a requester the data is theirs.
  assign instr_bus_r.data = mem_bus_r.data;
  assign data_bus_r.data  = mem_bus_r.data;

  // Forward the owner's request to memory and route the ack back. The strobe
  // follows the owner's live request so a withdrawal drops it immediately.
  always_comb begin
    mem_bus_r.re    = 1'b0;
    mem_bus_r.addr  = '0;
    mem_bus_r.sel   = '0;
    mem_bus_w.we    = 1'b0;
    mem_bus_w.addr  = '0;
    mem_bus_w.data  = '0;
    mem_bus_w.sel   = '0;
    instr_bus_r.ack = 1'b0;
    data_bus_r.ack  = 1'b0;
    data_bus_w.ack  = 1'b0;
    case (grant_q)
      GNT_INSTR: begin
        mem_bus_r.re    = instr_bus_r.re;
        mem_bus_r.addr  = instr_bus_r.addr;
        mem_bus_r.sel   = instr_bus_r.sel;
        instr_bus_r.ack = mem_bus_r.ack;
      end
      GNT_DATA_R: begin
        mem_bus_r.re   = data_bus_r.re;
        mem_bus_r.addr = data_bus_r.addr;
        mem_bus_r.sel  = data_bus_r.sel;
        data_bus_r.ack = mem_bus_r.ack;
      end
      GNT_DATA_W: begin
        mem_bus_w.we   = data_bus_w.we;
        mem_bus_w.addr = data_bus_w.addr;
        mem_bus_w.data = data_bus_w.data;
        mem_bus_w.sel  = data_bus_w.sel;
        data_bus_w.ack = mem_bus_w.ack;
      end
      default: begin
      end
    endcase
  end

endmodule
